logic_op_driver: RTL and testbench

//  Initiator side of the 32-bit logical-unit interface: accepts logic commands over a

---
 rtl/logic_op_driver.sv | 125 ++++++++++++
 tb/tb_logic_op_driver.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/logic_op_driver.sv
// Initiator for the combinational logical unit: takes a command, runs one or more
// chained passes through the unit, then holds the final result on a response handshake.
module logic_op_driver #(
  parameter int WIDTH = 32,
  parameter int REP_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  input  logic [2:0]       cmd_funct,
  input  logic [REP_W-1:0] cmd_reps,
  output logic [WIDTH-1:0] lu_a,
  output logic [WIDTH-1:0] lu_b,
  output logic [2:0]       lu_funct,
  input  logic [WIDTH-1:0] lu_res,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_zero,
  output logic [REP_W:0]   rsp_passes,
  output logic [1:0]       dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
  // valid never depends on ready, and the payload is held stable while valid && !ready.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam logic [REP_W:0]   PASS_ONE = {{REP_W{1'b0}}, 1'b1};
  localparam logic [REP_W-1:0] REP_ONE  = {{(REP_W-1){1'b0}}, 1'b1};

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [2:0]         funct_q, funct_d;
  logic [REP_W-1:0]   reps_q, reps_d;
  logic [REP_W:0]     passes_q, passes_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic               zero_q, zero_d;

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    funct_d   = funct_q;
    reps_d    = reps_q;
    passes_d  = passes_q;
    res_d     = res_q;
    zero_d    = zero_q;
    cmd_ready = 1'b0;
    rsp_valid = 1'b0;
    case (state_q)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          a_d      = cmd_a;
          b_d      = cmd_b;
          funct_d  = cmd_funct;
          reps_d   = cmd_reps;
          passes_d = '0;
          state_d  = EXEC;
        end
      end
      EXEC: begin
        res_d    = lu_res;
        zero_d   = (lu_res == '0);
        passes_d = passes_q + PASS_ONE;
        if (reps_q == '0) begin
          state_d = RESP;
        end else begin
          // Chain: this pass's result becomes operand a of the next pass.
          a_d    = lu_res;
          reps_d = reps_q - REP_ONE;
        end
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      funct_q  <= '0;
      reps_q   <= '0;
      passes_q <= '0;
      res_q    <= '0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      funct_q  <= funct_d;
      reps_q   <= reps_d;
      passes_q <= passes_d;
      res_q    <= res_d;
      zero_q   <= zero_d;
    end
  end

  assign lu_a       = a_q;
  assign lu_b       = b_q;
  assign lu_funct   = funct_q;
  assign rsp_data   = res_q;
  assign rsp_zero   = zero_q;
  assign rsp_passes = passes_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_logic_op_driver.sv
// Bench for logic_op_driver: a behavioural logical unit plus a transaction-level model
// that predicts each response and the cycle it must appear on.
module tb_logic_op_driver;

  localparam int WIDTH = 32;
  localparam int REP_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [WIDTH-1:0] cmd_a;
  logic [WIDTH-1:0] cmd_b;
  logic [2:0]       cmd_funct;
  logic [REP_W-1:0] cmd_reps;
  logic [WIDTH-1:0] lu_a;
  logic [WIDTH-1:0] lu_b;
  logic [2:0]       lu_funct;
  logic [WIDTH-1:0] lu_res;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_data;
  logic             rsp_zero;
  logic [REP_W:0]   rsp_passes;
  logic [1:0]       dbg_state;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int ready_mode = 1;  // 0 random, 1 always high, 2 always low

  logic [WIDTH-1:0] exp_q[$];
  logic [REP_W:0]   exp_pass_q[$];
  logic [WIDTH-1:0] exp_b_q[$];
  logic [2:0]       exp_f_q[$];
  int               due_q[$];

  logic_op_driver #(.WIDTH(WIDTH), .REP_W(REP_W)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_funct(cmd_funct), .cmd_reps(cmd_reps),
    .lu_a(lu_a), .lu_b(lu_b), .lu_funct(lu_funct), .lu_res(lu_res),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_zero(rsp_zero), .rsp_passes(rsp_passes),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL global_timeout act=running exp=finished");
    $fatal(1, "global timeout");
  end

  // ---------------- logical unit and model ----------------
  function automatic logic [WIDTH-1:0] lu_fn(input logic [WIDTH-1:0] a,
                                             input logic [WIDTH-1:0] b,
                                             input logic [2:0] f);
    case (f)
      3'd0: return a | b;
      3'd1: return a & b;
      3'd2: return a ^ b;
      3'd3: return ~a;
      3'd4: return ~(a | b);
      3'd5: return ~(a & b);
      3'd6: return ~(a ^ b);
      default: return ~b;
    endcase
  endfunction

  function automatic logic [WIDTH-1:0] model_chain(input logic [WIDTH-1:0] a,
                                                   input logic [WIDTH-1:0] b,
                                                   input logic [2:0] f,
                                                   input int reps);
    logic [WIDTH-1:0] x = a;
    for (int i = 0; i <= reps; i++) x = lu_fn(x, b, f);
    return x;
  endfunction

  always_comb lu_res = lu_fn(lu_a, lu_b, lu_funct);

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- scoreboard / compare ----------------
  always @(negedge clk) begin
    bit busy;
    bit exp_valid;
    if (rst) begin
      exp_q.delete(); exp_pass_q.delete(); exp_b_q.delete(); exp_f_q.delete(); due_q.delete();
    end else begin
      busy      = (exp_q.size() != 0);
      exp_valid = busy ? (cyc >= due_q[0]) : 1'b0;
      check("cmd_ready", 64'(cmd_ready), 64'(!busy));
      check("rsp_valid", 64'(rsp_valid), 64'(exp_valid));
      if (busy && rsp_valid) begin
        check("rsp_data", 64'(rsp_data), 64'(exp_q[0]));
        check("rsp_zero", 64'(rsp_zero), 64'(exp_q[0] == '0));
        check("rsp_passes", 64'(rsp_passes), 64'(exp_pass_q[0]));
      end
      if (busy && !exp_valid) begin
        check("lu_b", 64'(lu_b), 64'(exp_b_q[0]));
        check("lu_funct", 64'(lu_funct), 64'(exp_f_q[0]));
      end
      if (busy && rsp_valid && rsp_ready) begin
        void'(exp_q.pop_front()); void'(exp_pass_q.pop_front());
        void'(exp_b_q.pop_front()); void'(exp_f_q.pop_front()); void'(due_q.pop_front());
      end
      if (!busy && cmd_valid) begin
        exp_q.push_back(model_chain(cmd_a, cmd_b, cmd_funct, int'(cmd_reps)));
        exp_pass_q.push_back((REP_W+1)'(int'(cmd_reps) + 1));
        exp_b_q.push_back(cmd_b);
        exp_f_q.push_back(cmd_funct);
        due_q.push_back(cyc + int'(cmd_reps) + 2);
      end
    end
  end

  // ---------------- drivers ----------------
  initial begin
    rsp_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        0: rsp_ready = ($urandom_range(0, 3) != 0);
        1: rsp_ready = 1'b1;
        default: rsp_ready = 1'b0;
      endcase
    end
  end

  task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                      input logic [2:0] f, input logic [REP_W-1:0] r);
    int n = 0;
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_a = a; cmd_b = b; cmd_funct = f; cmd_reps = r;
    @(negedge clk);
    while (!cmd_ready && n < 200) begin n++; @(negedge clk); end
    if (!cmd_ready) check("accept_timeout", 64'(cmd_ready), 64'd1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp();
    int n = 0;
    @(negedge clk);
    while (!rsp_valid && n < 200) begin n++; @(negedge clk); end
    if (!rsp_valid) check("rsp_timeout", 64'(rsp_valid), 64'd1);
  endtask

  task automatic wait_done();
    int n = 0;
    @(negedge clk);
    while (exp_q.size() != 0 && n < 400) begin n++; @(negedge clk); end
    if (exp_q.size() != 0) check("done_timeout", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_lu_a"}, 64'(lu_a), 64'd0);
    check({tag, "_lu_b"}, 64'(lu_b), 64'd0);
    check({tag, "_lu_funct"}, 64'(lu_funct), 64'd0);
    check({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
    check({tag, "_rsp_data"}, 64'(rsp_data), 64'd0);
    check({tag, "_rsp_zero"}, 64'(rsp_zero), 64'd0);
    check({tag, "_rsp_passes"}, 64'(rsp_passes), 64'd0);
    check({tag, "_cmd_ready"}, 64'(cmd_ready), 64'd1);
    check({tag, "_state"}, 64'(dbg_state), 64'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [WIDTH-1:0] lits [8];
    rst = 1'b1; cmd_valid = 1'b0; cmd_a = '0; cmd_b = '0; cmd_funct = '0; cmd_reps = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("reset");

    // model pins
    lits = '{32'h00FF_FFFF, 32'h0000_00FF, 32'h00FF_FF00, 32'hFFFF_0000,
             32'hFF00_0000, 32'hFFFF_FF00, 32'hFF00_00FF, 32'hFF00_FF00};
    check("pin_or", 64'(model_chain(32'hF0F0_0000, 32'h0000_0F0F, 3'd0, 0)), 64'hF0F0_0F0F);
    check("pin_chain", 64'(model_chain(32'd1, 32'd3, 3'd2, 2)), 64'd2);
    check("pin_not_a_16", 64'(model_chain(32'd0, 32'd0, 3'd3, 15)), 64'd0);
    for (int f = 0; f < 8; f++)
      check("pin_funct", 64'(lu_fn(32'h0000_FFFF, 32'h00FF_00FF, 3'(f))), 64'(lits[f]));

    // single OR
    ready_mode = 1;
    send(32'hF0F0_0000, 32'h0000_0F0F, 3'd0, 4'd0);
    wait_rsp();
    check("or_data", 64'(rsp_data), 64'hF0F0_0F0F);
    check("or_zero", 64'(rsp_zero), 64'd0);
    check("or_passes", 64'(rsp_passes), 64'd1);
    wait_done();

    // every funct code
    for (int f = 0; f < 8; f++) begin
      send(32'h0000_FFFF, 32'h00FF_00FF, 3'(f), 4'd0);
      wait_rsp();
      check("funct_data", 64'(rsp_data), 64'(lits[f]));
      wait_done();
    end

    // chained XOR and zero result
    send(32'd1, 32'd3, 3'd2, 4'd2);
    wait_rsp();
    check("chain_data", 64'(rsp_data), 64'd2);
    check("chain_passes", 64'(rsp_passes), 64'd3);
    wait_done();
    send(32'd5, 32'd5, 3'd2, 4'd0);
    wait_rsp();
    check("xor_zero_data", 64'(rsp_data), 64'd0);
    check("xor_zero_flag", 64'(rsp_zero), 64'd1);
    wait_done();

    // backpressure: response held, new command parked until IDLE
    ready_mode = 2;
    send(32'h1234_5678, 32'h0F0F_0F0F, 3'd1, 4'd1);
    wait_rsp();
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_a = 32'hAAAA_0000; cmd_b = 32'h0000_5555; cmd_funct = 3'd0; cmd_reps = 4'd0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_valid", 64'(rsp_valid), 64'd1);
      check("bp_cmd_ready", 64'(cmd_ready), 64'd0);
      check("bp_data", 64'(rsp_data), 64'h0204_0608);
    end
    ready_mode = 1;
    begin
      int n = 0;
      @(negedge clk);
      while (!cmd_ready && n < 50) begin n++; @(negedge clk); end
      check("bp_accept", 64'(cmd_ready), 64'd1);
      @(posedge clk); #1 cmd_valid = 1'b0;
    end
    wait_rsp();
    check("bp_next_data", 64'(rsp_data), 64'hAAAA_5555);
    wait_done();

    // max repeat count
    send(32'd0, 32'd0, 3'd3, 4'hF);
    wait_rsp();
    check("max_passes", 64'(rsp_passes), 64'd16);
    check("max_data", 64'(rsp_data), 64'd0);
    wait_done();

    // reset during the second EXEC cycle
    send(32'hDEAD_BEEF, 32'h1111_1111, 3'd6, 4'd5);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("midreset");
    repeat (10) begin
      @(negedge clk);
      check("midreset_no_rsp", 64'(rsp_valid), 64'd0);
    end
    send(32'h0000_00F0, 32'h0000_000F, 3'd0, 4'd0);
    wait_rsp();
    check("post_reset_data", 64'(rsp_data), 64'h0000_00FF);
    wait_done();

    // randomized traffic with random response backpressure
    ready_mode = 0;
    for (int i = 0; i < 150; i++) begin
      send($urandom, ($urandom_range(0, 3) == 0) ? 32'd0 : WIDTH'($urandom),
           3'($urandom_range(0, 7)), REP_W'($urandom_range(0, 15)));
      repeat ($urandom_range(0, 3)) @(posedge clk);
    end
    wait_done();
    ready_mode = 1;
    repeat (3) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
